// File: rtl/core_pkg.sv
// Shared widths and the context-transfer state encoding for the per-core register bank.
package core_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned NUM_GPR_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SPILL,
    FILL,
    DONE
  } ctx_state_e;

endpackage

// File: rtl/ctx_xfer_fsm.sv
// Context spill/fill sequencer: walks every GPR index and moves it to or from a memory frame
// through a req/ack handshake.
module ctx_xfer_fsm
  import core_pkg::*;
#(
  parameter  int unsigned NUM_GPR = NUM_GPR_DEF,
  parameter  int unsigned ADDR_W  = ADDR_W_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_GPR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spill_start,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] ctx_base,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [IDX_W-1:0]  spill_idx
);

  localparam int unsigned          CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(NUM_GPR - 1);

  ctx_state_e        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    fill_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (spill_start || fill_start) begin
          state_d = spill_start ? SPILL : FILL;
          base_d  = ctx_base;
          idx_d   = '0;
        end
      end
      SPILL, FILL: begin
        mem_req = 1'b1;
        mem_we  = (state_q == SPILL);
        if (mem_ack) begin
          fill_we = (state_q == FILL);
          idx_d   = idx_q + CNT_W'(1);
          if (idx_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = base_q + ADDR_W'(idx_q);
  assign fill_idx  = idx_q[IDX_W-1:0];
  assign spill_idx = idx_q[IDX_W-1:0];

endmodule

// File: rtl/core_reg_bank.sv
// Per-core register bank: GPR array, PC and AR on a shared B-bus, with a context spill/fill
// engine that moves the whole GPR set to or from data memory.
module core_reg_bank
  import core_pkg::*;
#(
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned NUM_GPR = NUM_GPR_DEF,
  parameter  int unsigned ADDR_W  = ADDR_W_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_GPR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_sel,
  input  logic [IDX_W-1:0]  rd_sel,
  input  logic              inc_en,
  input  logic [IDX_W-1:0]  inc_sel,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_sel,
  input  logic              alu_ld_en,
  input  logic [IDX_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] din,
  input  logic              mem_read,
  input  logic              pc_wr,
  input  logic              pc_inc,
  input  logic              ar_wr,
  input  logic              spill_start,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] ctx_base,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] alu_opnd,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ar_out,
  output logic              busy,
  output logic              done
);

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0] rd_val;
  logic              fill_we;
  logic [IDX_W-1:0]  fill_idx, spill_idx;

  ctx_xfer_fsm #(
    .NUM_GPR (NUM_GPR),
    .ADDR_W  (ADDR_W)
  ) u_xfer (
    .clk         (clk),
    .rst_n       (rst_n),
    .spill_start (spill_start),
    .fill_start  (fill_start),
    .ctx_base    (ctx_base),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .busy        (busy),
    .done        (done),
    .fill_we     (fill_we),
    .fill_idx    (fill_idx),
    .spill_idx   (spill_idx)
  );

  // Select-compare muxes: a select with no matching register reads as zero.
  always_comb begin
    rd_val    = '0;
    alu_opnd  = '0;
    mem_wdata = '0;
    for (int unsigned r = 0; r < NUM_GPR; r++) begin
      if (rd_sel    == IDX_W'(r)) rd_val    = gpr_q[r];
      if (alu_sel   == IDX_W'(r)) alu_opnd  = gpr_q[r];
      if (spill_idx == IDX_W'(r)) mem_wdata = gpr_q[r];
    end
  end

  assign bus_out = mem_read ? din : rd_val;

  always_comb begin
    for (int unsigned r = 0; r < NUM_GPR; r++) begin
      gpr_d[r] = gpr_q[r];
      if (fill_we && fill_idx == IDX_W'(r)) begin
        gpr_d[r] = mem_rdata;
      end else if (!busy) begin
        if (clr_en && clr_sel == IDX_W'(r))          gpr_d[r] = '0;
        else if (wr_en && wr_sel == IDX_W'(r))       gpr_d[r] = bus_in;
        else if (alu_ld_en && alu_sel == IDX_W'(r))  gpr_d[r] = alu_res;
        else if (inc_en && inc_sel == IDX_W'(r))     gpr_d[r] = gpr_q[r] + DATA_W'(1);
      end
    end
    pc_d = pc_wr ? bus_in[ADDR_W-1:0] : (pc_inc ? pc_q + ADDR_W'(1) : pc_q);
    ar_d = ar_wr ? bus_in[ADDR_W-1:0] : ar_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q <= '{default: '0};
      pc_q  <= '0;
      ar_q  <= '0;
    end else begin
      gpr_q <= gpr_d;
      pc_q  <= pc_d;
      ar_q  <= ar_d;
    end
  end

  assign pc_out = pc_q;
  assign ar_out = ar_q;

endmodule

// File: tb/tb_core_reg_bank.sv
// Randomised scoreboard bench for core_reg_bank with a behavioural register/memory model.
module tb_core_reg_bank;

  localparam int NG = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, inc_en, clr_en, alu_ld_en, mem_read, pc_wr, pc_inc, ar_wr;
  logic [2:0]  wr_sel, rd_sel, inc_sel, clr_sel, alu_sel;
  logic [15:0] alu_res, bus_in, din, ctx_base, mem_rdata;
  logic        spill_start, fill_start, mem_ack;
  logic        mem_req, mem_we, busy, done;
  logic [15:0] mem_addr, mem_wdata, bus_out, alu_opnd, pc_out, ar_out;

  core_reg_bank #(.DATA_W(16), .NUM_GPR(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .inc_en(inc_en), .inc_sel(inc_sel), .clr_en(clr_en), .clr_sel(clr_sel),
    .alu_ld_en(alu_ld_en), .alu_sel(alu_sel), .alu_res(alu_res), .bus_in(bus_in),
    .din(din), .mem_read(mem_read), .pc_wr(pc_wr), .pc_inc(pc_inc), .ar_wr(ar_wr),
    .spill_start(spill_start), .fill_start(fill_start), .ctx_base(ctx_base),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_out(bus_out), .alu_opnd(alu_opnd),
    .pc_out(pc_out), .ar_out(ar_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_gpr [NG];
  logic [15:0] m_pc, m_ar;
  bit          m_busy;

  typedef enum int {K_STORE, K_LOAD, K_DONE} kind_e;
  typedef struct { kind_e kind; logic [15:0] addr; logic [15:0] data; } ev_t;
  ev_t exp_q[$];

  int ack_mode = 0;
  int stall    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Memory responder: acks a pending request after 0-2 random stall cycles, or every cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = 16'hA000 + mem_addr;
      if (mem_req && stall == 0) begin
        mem_ack = 1'b1;
        stall   = (ack_mode == 0) ? int'($urandom_range(0, 2)) : 0;
      end else begin
        mem_ack = 1'b0;
        if (mem_req && stall > 0) stall--;
      end
    end
  end

  // Monitor: every accepted transfer and every done pulse must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {mem_we, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_kind", mem_we ? K_STORE : K_LOAD, e.kind);
        check("xfer_addr", mem_addr, e.addr);
        if (mem_we) check("xfer_wdata", mem_wdata, e.data);
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", K_DONE, e.kind);
      end
    end
  end

  task automatic idle_in();
    wr_en = 0; inc_en = 0; clr_en = 0; alu_ld_en = 0; mem_read = 0;
    pc_wr = 0; pc_inc = 0; ar_wr = 0; spill_start = 0; fill_start = 0;
    wr_sel = 0; rd_sel = 0; inc_sel = 0; clr_sel = 0; alu_sel = 0;
    alu_res = 0; bus_in = 0; din = 0; ctx_base = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NG; i++) m_gpr[i] = '0;
    m_pc = '0; m_ar = '0; m_busy = 0;
  endtask

  task automatic check_reads();
    check("bus_out", bus_out, mem_read ? din : m_gpr[rd_sel]);
    check("alu_opnd", alu_opnd, m_gpr[alu_sel]);
    check("pc_out", pc_out, m_pc);
    check("ar_out", ar_out, m_ar);
  endtask

  // Apply lowest priority first so higher-priority writers overwrite the same target.
  task automatic model_step();
    logic [15:0] nx [NG];
    if (!m_busy) begin
      for (int i = 0; i < NG; i++) nx[i] = m_gpr[i];
      if (inc_en)    nx[inc_sel] = m_gpr[inc_sel] + 16'd1;
      if (alu_ld_en) nx[alu_sel] = alu_res;
      if (wr_en)     nx[wr_sel]  = bus_in;
      if (clr_en)    nx[clr_sel] = '0;
      for (int i = 0; i < NG; i++) m_gpr[i] = nx[i];
    end
    if (pc_wr)       m_pc = bus_in;
    else if (pc_inc) m_pc = m_pc + 16'd1;
    if (ar_wr)       m_ar = bus_in;
  endtask

  task automatic step(input bit chk);
    @(negedge clk);
    if (chk) check_reads();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [15:0] val);
    idle_in();
    wr_en = 1; wr_sel = 3'(idx); bus_in = val;
    step(1);
    idle_in();
  endtask

  task automatic read_reg(input string name, input int idx, input logic [15:0] val);
    idle_in();
    rd_sel = 3'(idx);
    @(negedge clk);
    check(name, bus_out, val);
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input bit sp, input bit fi, input logic [15:0] base);
    idle_in();
    ctx_base = base; spill_start = sp; fill_start = fi;
    step(1);
    idle_in();
    m_busy = 1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        @(negedge clk);
        check({name, "_busy_after_done"}, busy, 1'b0);
      end
    end
    if (!seen) fail_now({name, "_done_timeout"});
    @(posedge clk);
    #1;
    m_busy = 0;
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    idle_in();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1;
    step(1);

    // Mid-cycle asynchronous reset
    for (int i = 0; i < NG; i++) write_reg(i, 16'h5A00 + 16'(i));
    idle_in(); pc_wr = 1; ar_wr = 1; bus_in = 16'h0777; step(1); idle_in();
    rd_sel = 5;
    #2 rst_n = 0;
    #1;
    check("async_rst_bus_out", bus_out, 16'h0000);
    check("async_rst_pc", pc_out, 16'h0000);
    check("async_rst_ar", ar_out, 16'h0000);
    check("async_rst_mem_req", mem_req, 1'b0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    step(1);

    // Priority and wrap
    idle_in(); clr_en = 1; clr_sel = 3; wr_en = 1; wr_sel = 3; bus_in = 16'hBEEF;
    inc_en = 1; inc_sel = 3; step(1);
    read_reg("prio_clr_wins", 3, 16'h0000);
    idle_in(); wr_en = 1; wr_sel = 3; bus_in = 16'hBEEF; inc_en = 1; inc_sel = 3; step(1);
    read_reg("prio_wr_beats_inc", 3, 16'hBEEF);
    write_reg(5, 16'hFFFF);
    idle_in(); inc_en = 1; inc_sel = 5; step(1);
    read_reg("inc_wrap", 5, 16'h0000);

    // Randomised register traffic against the model
    for (int n = 0; n < 300; n++) begin
      idle_in();
      wr_en = 1'($urandom); inc_en = 1'($urandom); clr_en = ($urandom_range(0, 5) == 0);
      alu_ld_en = 1'($urandom); mem_read = ($urandom_range(0, 3) == 0);
      pc_wr = ($urandom_range(0, 7) == 0); pc_inc = 1'($urandom); ar_wr = ($urandom_range(0, 7) == 0);
      wr_sel = 3'($urandom); rd_sel = 3'($urandom); inc_sel = 3'($urandom);
      clr_sel = 3'($urandom); alu_sel = 3'($urandom);
      alu_res = 16'($urandom); din = 16'($urandom);
      bus_in = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(1);
    end

    // Bus mux and PC priority
    idle_in(); mem_read = 1; din = 16'h1234;
    @(negedge clk); check("bus_mem_bypass", bus_out, 16'h1234);
    @(posedge clk); #1;
    write_reg(6, 16'h6606);
    read_reg("bus_rd_r6", 6, 16'h6606);
    idle_in(); pc_wr = 1; pc_inc = 1; bus_in = 16'h0040; step(1); idle_in();
    @(negedge clk); check("pc_wr_beats_inc", pc_out, 16'h0040);
    @(posedge clk); #1;

    // Spill with random stalls
    for (int i = 0; i < NG; i++) write_reg(i, 16'h1000 + 16'(i));
    ack_mode = 0;
    for (int i = 0; i < NG; i++) exp_q.push_back('{K_STORE, 16'h0200 + 16'(i), 16'h1000 + 16'(i)});
    exp_q.push_back('{K_DONE, 16'h0, 16'h0});
    start_xfer(1, 0, 16'h0200);
    wait_done("spill");

    // Fill with every-cycle ack; concurrent GPR write is dropped, PC keeps counting
    ack_mode = 1;
    for (int i = 0; i < NG; i++) exp_q.push_back('{K_LOAD, 16'h0300 + 16'(i), 16'h0});
    exp_q.push_back('{K_DONE, 16'h0, 16'h0});
    start_xfer(0, 1, 16'h0300);
    wr_en = 1; wr_sel = 2; bus_in = 16'hDEAD; pc_inc = 1;
    step(0);
    idle_in();
    wait_done("fill");
    for (int i = 0; i < NG; i++) m_gpr[i] = 16'hA300 + 16'(i);
    read_reg("fill_r2_dropped_wr", 2, 16'hA302);
    for (int i = 0; i < NG; i++) begin
      idle_in(); rd_sel = 3'(i); alu_sel = 3'(7 - i); step(1);
    end

    // Simultaneous starts pick spill; a start while busy is ignored
    ack_mode = 0;
    for (int i = 0; i < NG; i++) exp_q.push_back('{K_STORE, 16'h0400 + 16'(i), 16'hA300 + 16'(i)});
    exp_q.push_back('{K_DONE, 16'h0, 16'h0});
    start_xfer(1, 1, 16'h0400);
    spill_start = 1; fill_start = 1; ctx_base = 16'h0800;
    step(0);
    idle_in();
    wait_done("collide");
    repeat (3) step(1);
    check("no_restart_req", mem_req, 1'b0);

    // Reset while the spill engine is at idx 4
    ack_mode = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{K_STORE, 16'h0500 + 16'(i), 16'hA300 + 16'(i)});
    start_xfer(1, 0, 16'h0500);
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("midxfer_rst_req", mem_req, 1'b0);
    check("midxfer_rst_busy", busy, 1'b0);
    check("midxfer_stores_seen", exp_q.size(), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_no_req", mem_req, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
